// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell reused across WIDTH cycles with a borrow flip-flop.
//
// Handshake: start is a request sampled on any rising edge where busy=0
// (IDLE or DONE). The edge that accepts start also captures a, b and bin.
// done is a one-cycle pulse. diff/bout are valid from the done cycle and
// hold until the next completion or reset. start while busy=1 is dropped.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             last;
  logic             a_i;
  logic             b_i;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] res_next;

  // A start is accepted whenever the engine is not mid-operation.
  assign load = start && (state != SHIFT);
  assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Full-subtractor cell on the current LSBs plus result shift-in at the MSB.
  always_comb begin
    a_i      = a_sr[0];
    b_i      = b_sr[0];
    d        = a_i ^ b_i ^ br;
    br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    d_msb    = '0;
    d_msb[WIDTH-1] = d;
    res_next = (res_sr >> 1) | d_msb;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> SHIFT -> DONE -> (IDLE | SHIFT).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = load ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shift, and result commit on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      br     <= br_next;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff <= res_next;
        bout <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor: a WIDTH=4 and a WIDTH=8 instance,
// directed vectors, expected {bout,diff} queued by the drivers and checked
// by a monitor on every done pulse.
module tb_serial_borrow_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT W=4 ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;

  serial_borrow_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  // ---------------- DUT W=8 ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  serial_borrow_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  // ---------------- scoreboard ----------------
  logic [4:0] exp4_q[$];
  logic [8:0] exp8_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done4 === 1'b1) begin
        if (exp4_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL w4_unexpected_done: got done=1 expected no done at %0t", $time);
        end else begin
          check("w4_result", {27'd0, bout4, diff4}, {27'd0, exp4_q.pop_front()});
        end
      end
      if (done8 === 1'b1) begin
        if (exp8_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL w8_unexpected_done: got done=1 expected no done at %0t", $time);
        end else begin
          check("w8_result", {23'd0, bout8, diff8}, {23'd0, exp8_q.pop_front()});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge of the done cycle, so a
  // following call without an extra wait issues start during DONE.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                     input logic [4:0] ex, input logic pulse_mid);
    logic [4:0] prev;
    prev   = {bout4, diff4};
    start4 = 1'b1;
    a4     = av;
    b4     = bv;
    bin4   = bi;
    exp4_q.push_back(ex);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4     = 4'($urandom_range(0, 15));
    b4     = 4'($urandom_range(0, 15));
    bin4   = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w4_busy", {31'd0, busy4}, 32'd1);
      check("w4_no_early_done", {31'd0, done4}, 32'd0);
      check("w4_hold", {27'd0, bout4, diff4}, {27'd0, prev});
      if (pulse_mid && i == 0) begin
        start4 = 1'b1;
        a4     = 4'd1;
        b4     = 4'd1;
        bin4   = 1'b0;
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);
    check("w4_latency_done", {31'd0, done4}, 32'd1);
    check("w4_busy_low_at_done", {31'd0, busy4}, 32'd0);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     input logic [8:0] ex);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    bin8   = bi;
    exp8_q.push_back(ex);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8     = 8'($urandom_range(0, 255));
    b8     = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("w8_busy", {31'd0, busy8}, 32'd1);
      check("w8_no_early_done", {31'd0, done8}, 32'd0);
    end
    @(negedge clk);
    check("w8_latency_done", {31'd0, done8}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("reset_busy4", {31'd0, busy4}, 32'd0);
    check("reset_done4", {31'd0, done4}, 32'd0);
    check("reset_out4", {27'd0, bout4, diff4}, 32'd0);
    check("reset_out8", {23'd0, bout8, diff8}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1 / T2 and extra directed vectors, idle cycle between ops
    op4(4'd9,  4'd5,  1'b0, 5'h04, 1'b0); @(negedge clk);
    op4(4'd5,  4'd9,  1'b0, 5'h1C, 1'b0); @(negedge clk);
    op4(4'd0,  4'd0,  1'b1, 5'h1F, 1'b0); @(negedge clk);
    op4(4'd15, 4'd0,  1'b1, 5'h0E, 1'b0); @(negedge clk);
    op4(4'd8,  4'd7,  1'b1, 5'h00, 1'b0); @(negedge clk);
    op4(4'd7,  4'd8,  1'b0, 5'h1F, 1'b0); @(negedge clk);

    // T3: start pulsed while busy must be ignored
    op4(4'd12, 4'd3,  1'b1, 5'h08, 1'b0);
    @(negedge clk);
    op4(4'd12, 4'd3,  1'b1, 5'h08, 1'b1);
    repeat (8) @(negedge clk);

    // T5: back-to-back, second start issued during the DONE cycle
    op4(4'd15, 4'd15, 1'b1, 5'h1F, 1'b0);
    op4(4'd3,  4'd1,  1'b0, 5'h02, 1'b0);
    @(negedge clk);

    // T4: reset in SHIFT with cnt=2, no done afterwards
    start4 = 1'b1;
    a4     = 4'd6;
    b4     = 4'd2;
    bin4   = 1'b0;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy4}, 32'd0);
    check("rst_mid_done", {31'd0, done4}, 32'd0);
    check("rst_mid_out", {27'd0, bout4, diff4}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    op4(4'd10, 4'd4,  1'b1, 5'h05, 1'b0);
    @(negedge clk);

    // T6 corners and directed vectors at WIDTH=8
    op8(8'd0,   8'd255, 1'b0, 9'h101); @(negedge clk);
    op8(8'd255, 8'd0,   1'b0, 9'h0FF); @(negedge clk);
    op8(8'd128, 8'd128, 1'b1, 9'h1FF); @(negedge clk);
    op8(8'd200, 8'd100, 1'b1, 9'h063); @(negedge clk);
    op8(8'd100, 8'd200, 1'b0, 9'h19C);
    op8(8'd170, 8'd85,  1'b0, 9'h055); @(negedge clk);
    op8(8'd0,   8'd0,   1'b0, 9'h000);
    repeat (12) @(negedge clk);

    check("w4_queue_drained", exp4_q.size(), 32'd0);
    check("w8_queue_drained", exp8_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
